// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcode/func constants, ALU and access-size encodings,
// multicycle FSM states and the decoded-instruction record.
package dlx_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQZ  = 6'h04;
   localparam logic [5:0] OP_BNEZ  = 6'h05;
   localparam logic [5:0] OP_ADDUI = 6'h09;
   localparam logic [5:0] OP_SUBI  = 6'h0a;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LHI   = 6'h0f;
   localparam logic [5:0] OP_TRAP  = 6'h11;
   localparam logic [5:0] OP_JR    = 6'h12;
   localparam logic [5:0] OP_JALR  = 6'h13;
   localparam logic [5:0] OP_SLTI  = 6'h1a;
   localparam logic [5:0] OP_SGTI  = 6'h1b;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL = 6'h04;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_SEQ = 6'h28;
   localparam logic [5:0] FN_SNE = 6'h29;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_SLL = 4'b0010;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_SEQ = 4'b1100;
   localparam logic [3:0] ALU_SGT = 4'b1101;
   localparam logic [3:0] ALU_SLT = 4'b1110;

   localparam logic [1:0] DSZ_B = 2'b00;
   localparam logic [1:0] DSZ_H = 2'b01;
   localparam logic [1:0] DSZ_W = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      C_ALU_R, C_ALU_I, C_BEQZ, C_BNEZ, C_JUMP, C_JLINK,
      C_LOAD, C_STORE, C_LHI, C_TRAP, C_ILL
   } class_e;

   typedef struct packed {
      class_e     cls;
      logic [3:0] alu;
      logic [1:0] dsize;
      logic       sign_ext;
      logic       set_inv;
      logic       reg_dst;
      logic       link;
      logic       jr;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/mc_control_if.sv
// Control-unit bus: instruction/data memory handshakes, datapath strobes and
// selects, IR and sticky status. master = control unit, slave = datapath/memories.
interface mc_control_if #(parameter int DATA_W = 32);
   logic [DATA_W-1:0] imemData;
   logic              imemReady;
   logic              dmemReady;
   logic              zero;
   logic              imemReq, dmemReq;
   logic              irWr, pcWr, regWr, memRd, memWr;
   logic              regDst, aluSrc, signExt, link, setInv, jr;
   logic [3:0]        aluCtrl;
   logic [1:0]        dSize;
   logic [DATA_W-1:0] ir;
   logic              halted, illegal, memErr;

   modport master (
      input  imemData, imemReady, dmemReady, zero,
      output imemReq, dmemReq, irWr, pcWr, regWr, memRd, memWr,
             regDst, aluSrc, signExt, link, setInv, jr, aluCtrl, dSize,
             ir, halted, illegal, memErr
   );

   modport slave (
      output imemData, imemReady, dmemReady, zero,
      input  imemReq, dmemReq, irWr, pcWr, regWr, memRd, memWr,
             regDst, aluSrc, signExt, link, setInv, jr, aluCtrl, dSize,
             ir, halted, illegal, memErr
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational IR classifier: opcode/func -> instruction class plus the
// datapath selects that depend only on the instruction.
module mc_decode import dlx_pkg::*; (
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output dec_t       o_dec
);

   always_comb begin
      o_dec.cls      = C_ILL;
      o_dec.alu      = ALU_NOP;
      o_dec.dsize    = DSZ_B;
      o_dec.sign_ext = 1'b1;
      o_dec.set_inv  = 1'b0;
      o_dec.reg_dst  = 1'b0;
      o_dec.link     = 1'b0;
      o_dec.jr       = 1'b0;
      o_dec.illegal  = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            o_dec.cls     = C_ALU_R;
            o_dec.reg_dst = 1'b1;
            case (i_func)
               FN_ADD:  o_dec.alu = ALU_ADD;
               FN_SUB:  o_dec.alu = ALU_SUB;
               FN_AND:  o_dec.alu = ALU_AND;
               FN_SLL:  o_dec.alu = ALU_SLL;
               FN_SEQ:  o_dec.alu = ALU_SEQ;
               FN_SNE:  begin o_dec.alu = ALU_SEQ; o_dec.set_inv = 1'b1; end
               default: begin o_dec.cls = C_ILL; o_dec.reg_dst = 1'b0; end
            endcase
         end
         OP_ADDUI: begin o_dec.cls = C_ALU_I; o_dec.alu = ALU_ADD; o_dec.sign_ext = 1'b0; end
         OP_SUBI:  begin o_dec.cls = C_ALU_I; o_dec.alu = ALU_SUB; end
         OP_ORI:   begin o_dec.cls = C_ALU_I; o_dec.alu = ALU_OR;  end
         OP_SLTI:  begin o_dec.cls = C_ALU_I; o_dec.alu = ALU_SLT; end
         OP_SGTI:  begin o_dec.cls = C_ALU_I; o_dec.alu = ALU_SGT; end
         OP_BEQZ:  o_dec.cls = C_BEQZ;
         OP_BNEZ:  o_dec.cls = C_BNEZ;
         OP_J:     o_dec.cls = C_JUMP;
         OP_JR:    begin o_dec.cls = C_JUMP;  o_dec.jr = 1'b1; end
         OP_JAL:   begin o_dec.cls = C_JLINK; o_dec.link = 1'b1; end
         OP_JALR:  begin o_dec.cls = C_JLINK; o_dec.link = 1'b1; o_dec.jr = 1'b1; end
         OP_LB:    begin o_dec.cls = C_LOAD;  o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_B; end
         OP_LH:    begin o_dec.cls = C_LOAD;  o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_H; end
         OP_LW:    begin o_dec.cls = C_LOAD;  o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_W; end
         OP_SB:    begin o_dec.cls = C_STORE; o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_B; end
         OP_SH:    begin o_dec.cls = C_STORE; o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_H; end
         OP_SW:    begin o_dec.cls = C_STORE; o_dec.alu = ALU_ADD; o_dec.dsize = DSZ_W; end
         OP_LHI:   o_dec.cls = C_LHI;
         OP_TRAP:  o_dec.cls = C_TRAP;
         default:  o_dec.cls = C_ILL;
      endcase
      o_dec.illegal = (o_dec.cls == C_ILL);
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle DLX control unit: IR + FETCH/DECODE/EXEC/MEM/WB sequencer.
// Optional memory-wait watchdog enabled by defining MC_CONTROL_TIMEOUT_EN.
module mc_control import dlx_pkg::*; #(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic          clk,
   input logic          rst,
   mc_control_if.master bus
);

   state_e            r_state, w_next;
   logic [DATA_W-1:0] r_ir;
   logic              r_halted, r_illegal;
   dec_t              w_dec;
   logic              w_tmo;
   logic              w_imem_req, w_dmem_req, w_ir_wr, w_pc_wr, w_reg_wr, w_mem_rd, w_mem_wr;
   logic              w_reg_dst, w_alu_src, w_sign_ext, w_link, w_set_inv, w_jr;
   logic [3:0]        w_alu;
   logic [1:0]        w_dsize;
   logic              w_is_imm;

   mc_decode u_dec (
      .i_op   (r_ir[31:26]),
      .i_func (r_ir[5:0]),
      .o_dec  (w_dec)
   );

   assign w_is_imm = (w_dec.cls == C_ALU_I) || (w_dec.cls == C_LOAD) ||
                     (w_dec.cls == C_STORE) || (w_dec.cls == C_LHI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ir      <= '0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_ir_wr)
            r_ir <= bus.imemData;
         if (r_state == S_DECODE && w_dec.cls == C_TRAP)
            r_halted <= 1'b1;
         if (r_state == S_DECODE && w_dec.illegal)
            r_illegal <= 1'b1;
      end
   end

`ifdef MC_CONTROL_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0] r_wait;
   logic             r_mem_err;
   logic             w_waiting;

   assign w_waiting = (r_state == S_FETCH && !bus.imemReady) ||
                      (r_state == S_MEM   && !bus.dmemReady);
   // Fires on the TIMEOUT_CYC-th consecutive not-ready cycle of one state visit.
   assign w_tmo = w_waiting && (r_wait == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait    <= '0;
         r_mem_err <= 1'b0;
      end else begin
         if (w_next != r_state)
            r_wait <= '0;
         else if (w_waiting)
            r_wait <= r_wait + 1'b1;
         if (w_tmo)
            r_mem_err <= 1'b1;
      end
   end

   assign bus.memErr = r_mem_err;
`else
   assign w_tmo = 1'b0;
   // No watchdog in this build; TIMEOUT_CYC folds away to a constant 0.
   assign bus.memErr = 1'b0 & (TIMEOUT_CYC > 0);
`endif

   always_comb begin
      w_next     = r_state;
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_ir_wr    = 1'b0;
      w_pc_wr    = 1'b0;
      w_reg_wr   = 1'b0;
      w_mem_rd   = 1'b0;
      w_mem_wr   = 1'b0;
      w_reg_dst  = 1'b0;
      w_alu_src  = 1'b0;
      w_sign_ext = 1'b0;
      w_link     = 1'b0;
      w_set_inv  = 1'b0;
      w_jr       = 1'b0;
      w_alu      = ALU_NOP;
      w_dsize    = DSZ_B;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            w_imem_req = 1'b1;
            if (bus.imemReady) begin
               w_ir_wr = 1'b1;
               w_pc_wr = 1'b1;
               w_next  = S_DECODE;
            end else if (w_tmo) begin
               w_next = S_HALT;
            end
         end
         S_DECODE: w_next = (w_dec.illegal || w_dec.cls == C_TRAP) ? S_HALT : S_EXEC;
         S_EXEC: begin
            w_alu      = w_dec.alu;
            w_alu_src  = w_is_imm;
            w_sign_ext = w_dec.sign_ext;
            w_set_inv  = w_dec.set_inv;
            w_jr       = w_dec.jr;
            case (w_dec.cls)
               C_BEQZ:          begin w_pc_wr = bus.zero;  w_next = S_FETCH; end
               C_BNEZ:          begin w_pc_wr = !bus.zero; w_next = S_FETCH; end
               C_JUMP:          begin w_pc_wr = 1'b1;      w_next = S_FETCH; end
               C_JLINK:         begin w_pc_wr = 1'b1;      w_next = S_WB;    end
               C_LOAD, C_STORE: w_next = S_MEM;
               default:         w_next = S_WB;
            endcase
         end
         S_MEM: begin
            // Address selects stay up so the datapath holds the effective address.
            w_dmem_req = 1'b1;
            w_mem_rd   = (w_dec.cls == C_LOAD);
            w_mem_wr   = (w_dec.cls == C_STORE);
            w_dsize    = w_dec.dsize;
            w_alu      = w_dec.alu;
            w_alu_src  = 1'b1;
            w_sign_ext = w_dec.sign_ext;
            if (bus.dmemReady)
               w_next = (w_dec.cls == C_LOAD) ? S_WB : S_FETCH;
            else if (w_tmo)
               w_next = S_HALT;
         end
         S_WB: begin
            w_reg_wr  = 1'b1;
            w_reg_dst = w_dec.reg_dst;
            w_link    = w_dec.link;
            w_next    = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.imemReq = w_imem_req;
   assign bus.dmemReq = w_dmem_req;
   assign bus.irWr    = w_ir_wr;
   assign bus.pcWr    = w_pc_wr;
   assign bus.regWr   = w_reg_wr;
   assign bus.memRd   = w_mem_rd;
   assign bus.memWr   = w_mem_wr;
   assign bus.regDst  = w_reg_dst;
   assign bus.aluSrc  = w_alu_src;
   assign bus.signExt = w_sign_ext;
   assign bus.link    = w_link;
   assign bus.setInv  = w_set_inv;
   assign bus.jr      = w_jr;
   assign bus.aluCtrl = w_alu;
   assign bus.dSize   = w_dsize;
   assign bus.ir      = r_ir;
   assign bus.halted  = r_halted;
   assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a per-cycle expectation queue is built from
// the instruction tables, then replayed against the DUT one cycle per entry.
module tb_mc_control;
   import dlx_pkg::*;

   localparam int DATA_W = 32;
   localparam int TMO    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_control_if #(.DATA_W(DATA_W)) bus ();
   mc_control #(.DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic       imemReq, dmemReq, irWr, pcWr, regWr, memRd, memWr;
      logic       regDst, aluSrc, signExt, setInv, link, jr;
      logic [3:0] alu;
      logic [1:0] dsz;
      logic       halted, illegal, memErr;
   } sig_t;

   typedef struct {
      logic        ir_rdy, dm_rdy, z;
      logic [31:0] idata;
      sig_t        exp, msk;
      logic        chk_ir;
      logic [31:0] ir;
   } ent_t;

   ent_t  q[$];
   string tq[$];
   int    checks = 0;
   int    errors = 0;
   logic  st_halt, st_ill, st_merr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic sig_t sample();
      sig_t s;
      s.imemReq = bus.imemReq; s.dmemReq = bus.dmemReq; s.irWr = bus.irWr;
      s.pcWr = bus.pcWr; s.regWr = bus.regWr; s.memRd = bus.memRd; s.memWr = bus.memWr;
      s.regDst = bus.regDst; s.aluSrc = bus.aluSrc; s.signExt = bus.signExt;
      s.setInv = bus.setInv; s.link = bus.link; s.jr = bus.jr;
      s.alu = bus.aluCtrl; s.dsz = bus.dSize;
      s.halted = bus.halted; s.illegal = bus.illegal; s.memErr = bus.memErr;
      return s;
   endfunction

   function automatic ent_t blank(input logic ir_rdy, input logic dm_rdy);
      ent_t e;
      e.ir_rdy = ir_rdy; e.dm_rdy = dm_rdy; e.z = 1'b0; e.idata = 32'hdead_beef;
      e.exp = '0; e.msk = '0;
      e.msk.imemReq = 1'b1; e.msk.dmemReq = 1'b1; e.msk.irWr = 1'b1; e.msk.pcWr = 1'b1;
      e.msk.regWr = 1'b1; e.msk.memRd = 1'b1; e.msk.memWr = 1'b1;
      e.msk.halted = 1'b1; e.msk.illegal = 1'b1; e.msk.memErr = 1'b1;
      e.exp.halted = st_halt; e.exp.illegal = st_ill; e.exp.memErr = st_merr;
      e.chk_ir = 1'b0; e.ir = '0;
      return e;
   endfunction

   task automatic push(input ent_t e, input string tag);
      q.push_back(e);
      tq.push_back(tag);
   endtask

   function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return fn inside {6'h04, 6'h20, 6'h22, 6'h24, 6'h28, 6'h29};
      return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a, 6'h0d, 6'h0f, 6'h11,
                        6'h12, 6'h13, 6'h1a, 6'h1b, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b};
   endfunction

   task automatic push_wb(input logic rd, input logic lk, input string nm);
      ent_t e;
      e = blank(1'b1, 1'b1);
      e.exp.regWr = 1'b1;
      e.msk.regDst = 1'b1; e.exp.regDst = rd;
      e.msk.link = 1'b1;   e.exp.link = lk;
      push(e, {nm, ".wb"});
   endtask

   task automatic push_halt(input int n, input string nm);
      for (int i = 0; i < n; i++) push(blank(1'b1, 1'b1), {nm, ".halt"});
   endtask

   // Expected per-cycle behaviour of one instruction, from the opcode tables.
   task automatic sched(input logic [31:0] ins, input int iw, input int dw,
                        input logic z, input string nm);
      ent_t e;
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      for (int i = 0; i < iw; i++) begin
         e = blank(1'b0, 1'b1); e.exp.imemReq = 1'b1; push(e, {nm, ".fwait"});
      end
      e = blank(1'b1, 1'b1); e.idata = ins;
      e.exp.imemReq = 1'b1; e.exp.irWr = 1'b1; e.exp.pcWr = 1'b1;
      push(e, {nm, ".fetch"});
      e = blank(1'b1, 1'b1); e.chk_ir = 1'b1; e.ir = ins;
      push(e, {nm, ".dec"});
      if (op == 6'h11) begin st_halt = 1'b1; return; end
      if (!legal(op, fn)) begin st_ill = 1'b1; return; end
      e = blank(1'b1, 1'b1); e.z = z;
      case (op)
         6'h00: begin
            e.msk.alu = 4'hf; e.msk.setInv = 1'b1; e.msk.aluSrc = 1'b1;
            case (fn)
               6'h20: e.exp.alu = 4'b0100;
               6'h22: e.exp.alu = 4'b0101;
               6'h24: e.exp.alu = 4'b1000;
               6'h04: e.exp.alu = 4'b0010;
               default: e.exp.alu = 4'b1100;
            endcase
            e.exp.setInv = (fn == 6'h29);
            push(e, {nm, ".exec"});
            push_wb(1'b1, 1'b0, nm);
         end
         6'h09, 6'h0a, 6'h0d, 6'h1a, 6'h1b: begin
            e.msk.alu = 4'hf; e.msk.aluSrc = 1'b1; e.exp.aluSrc = 1'b1;
            case (op)
               6'h09: e.exp.alu = 4'b0100;
               6'h0a: e.exp.alu = 4'b0101;
               6'h0d: e.exp.alu = 4'b1001;
               6'h1a: e.exp.alu = 4'b1110;
               default: e.exp.alu = 4'b1101;
            endcase
            if (op == 6'h09 || op == 6'h0a) begin
               e.msk.signExt = 1'b1; e.exp.signExt = (op == 6'h0a);
            end
            push(e, {nm, ".exec"});
            push_wb(1'b0, 1'b0, nm);
         end
         6'h04, 6'h05: begin
            e.exp.pcWr = (op == 6'h04) ? z : !z;
            push(e, {nm, ".exec"});
         end
         6'h02, 6'h12, 6'h03, 6'h13: begin
            e.exp.pcWr = 1'b1; e.msk.jr = 1'b1; e.exp.jr = (op == 6'h12 || op == 6'h13);
            push(e, {nm, ".exec"});
            if (op == 6'h03 || op == 6'h13) push_wb(1'b0, 1'b1, nm);
         end
         6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: begin
            e.msk.alu = 4'hf; e.exp.alu = 4'b0100; e.msk.aluSrc = 1'b1; e.exp.aluSrc = 1'b1;
            push(e, {nm, ".exec"});
            for (int i = 0; i <= dw; i++) begin
               e = blank(1'b1, (i == dw));
               e.exp.dmemReq = 1'b1;
               e.exp.memRd = !op[3];
               e.exp.memWr = op[3];
               e.msk.dsz = 2'b11;
               e.exp.dsz = (op[1:0] == 2'b00) ? 2'b00 : (op[1:0] == 2'b01) ? 2'b01 : 2'b10;
               push(e, {nm, ".mem"});
            end
            if (!op[3]) push_wb(1'b0, 1'b0, nm);
         end
         default: begin
            push(e, {nm, ".exec"});
            push_wb(1'b0, 1'b0, nm);
         end
      endcase
   endtask

   task automatic run_q();
      ent_t        e;
      string       t;
      logic [21:0] gv, ev, mv;
      while (q.size() > 0) begin
         e = q.pop_front();
         t = tq.pop_front();
         @(posedge clk); #1;
         bus.imemReady = e.ir_rdy;
         bus.dmemReady = e.dm_rdy;
         bus.zero      = e.z;
         bus.imemData  = e.idata;
         @(negedge clk);
         gv = sample(); ev = e.exp; mv = e.msk;
         chk(t, {10'b0, gv & mv}, {10'b0, ev & mv});
         if (e.chk_ir) chk({t, ".ir"}, bus.ir, e.ir);
      end
   endtask

   task automatic do_reset(input string nm);
      logic [21:0] gv;
      #1 rst = 1'b1;
      #1 gv = sample();
      chk({nm, ".rst_out"}, {10'b0, gv}, 32'h0);
      chk({nm, ".rst_ir"}, bus.ir, 32'h0);
      bus.imemReady = 1'b0;
      bus.dmemReady = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      st_halt = 1'b0; st_ill = 1'b0; st_merr = 1'b0;
      @(negedge clk);
      gv = sample();
      chk({nm, ".idle_out"}, {10'b0, gv}, 32'h0);
   endtask

   initial begin
      ent_t e;
      bus.imemData = '0; bus.imemReady = 1'b0; bus.dmemReady = 1'b0; bus.zero = 1'b0;
      st_halt = 1'b0; st_ill = 1'b0; st_merr = 1'b0;
      do_reset("r0");

      sched(32'h0043_2020, 0, 0, 1'b0, "add");
      sched(32'h0043_2029, 1, 0, 1'b0, "sne");
      sched({6'h23, 26'h022_0010}, 0, 3, 1'b0, "lw");
      sched({6'h2b, 26'h022_0004}, 0, 1, 1'b0, "sw");
      sched({6'h04, 26'h020_0040}, 0, 0, 1'b1, "beqz1");
      sched({6'h04, 26'h020_0040}, 0, 0, 1'b0, "beqz0");
      sched({6'h05, 26'h020_0040}, 2, 0, 1'b0, "bnez0");
      sched({6'h05, 26'h020_0040}, 0, 0, 1'b1, "bnez1");
      sched({6'h02, 26'h000_0100}, 0, 0, 1'b0, "j");
      sched({6'h12, 26'h020_0000}, 0, 0, 1'b0, "jr");
      sched({6'h03, 26'h000_0200}, 0, 0, 1'b0, "jal");
      sched({6'h13, 26'h040_0000}, 0, 0, 1'b0, "jalr");
      sched({6'h09, 26'h022_8000}, 0, 0, 1'b0, "addui");
      sched({6'h0a, 26'h022_0001}, 0, 0, 1'b0, "subi");
      sched({6'h0d, 26'h022_00ff}, 0, 0, 1'b0, "ori");
      sched({6'h1a, 26'h022_0005}, 0, 0, 1'b0, "slti");
      sched({6'h1b, 26'h022_0005}, 0, 0, 1'b0, "sgti");
      sched({6'h0f, 26'h002_1234}, 0, 0, 1'b0, "lhi");
      sched({6'h20, 26'h022_0003}, 0, 1, 1'b0, "lb");
      sched({6'h21, 26'h022_0002}, 0, 0, 1'b0, "lh");
      sched({6'h28, 26'h022_0001}, 0, 0, 1'b0, "sb");
      sched({6'h29, 26'h022_0002}, 0, 2, 1'b0, "sh");
      sched(32'h0043_2004, 0, 0, 1'b0, "sll");
      sched(32'h0043_2024, 0, 0, 1'b0, "and");
      sched(32'h0043_2022, 0, 0, 1'b0, "sub");
      sched(32'h0043_2028, 0, 0, 1'b0, "seq");
      sched({6'h11, 26'h000_0000}, 0, 0, 1'b0, "trap");
      push_halt(3, "trap");
      run_q();

      do_reset("r1");
      sched({6'h3f, 26'h3ff_ffff}, 0, 0, 1'b0, "illop");
      push_halt(3, "illop");
      run_q();

      do_reset("r2");
      sched(32'h0043_203f, 0, 0, 1'b0, "illfn");
      push_halt(2, "illfn");
      run_q();

      do_reset("r3");
      sched(32'h0043_2020, 0, 0, 1'b0, "add2");
      sched({6'h23, 26'h022_0010}, 0, 5, 1'b0, "lwrst");
      while (q.size() > 8) begin
         void'(q.pop_back());
         void'(tq.pop_back());
      end
      run_q();

      do_reset("r4");
`ifdef MC_CONTROL_TIMEOUT_EN
      for (int i = 0; i < TMO; i++) begin
         e = blank(1'b0, 1'b1); e.exp.imemReq = 1'b1; push(e, "tmo.wait");
      end
      st_merr = 1'b1;
      for (int i = 0; i < 3; i++) push(blank(1'b0, 1'b1), "tmo.halt");
`else
      for (int i = 0; i < 10; i++) begin
         e = blank(1'b0, 1'b1); e.exp.imemReq = 1'b1; push(e, "nowd.wait");
      end
`endif
      run_q();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
